// File: rtl/mult_seq_core.sv
`default_nettype none
// ============================================================================
//  Module      : mult_seq_core
//  Description : Sequential shift-add multiplier (N-bit operands, 2N-bit
//                product in A:B) with signed/unsigned mode, start/done
//                handshake and busy flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_seq_core #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         load_b,
  input  logic         mode_signed,
  input  logic [N-1:0] S,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic         X,
  output logic         busy,
  output logic         done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST_CNT = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR      = 3'd1,
    ADD      = 3'd2,
    SHIFT    = 3'd3,
    DONE     = 3'd4,
    WAIT_REL = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            x_q, x_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sgn_q, sgn_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // N+1-bit adder operands: sign-extended in signed mode, zero-extended
  // otherwise. The last signed iteration subtracts because the multiplier's
  // MSB carries negative weight in two's complement.
  logic [N:0]      w_base;
  logic [N:0]      w_opnd;
  logic [N:0]      w_sum;
  logic            w_last;

  assign w_last = (cnt_q == C_LAST_CNT);
  assign w_base = sgn_q ? {a_q[N-1], a_q} : {1'b0, a_q};
  assign w_opnd = sgn_q ? {S[N-1], S}     : {1'b0, S};
  assign w_sum  = (sgn_q && w_last) ? (w_base - w_opnd) : (w_base + w_opnd);

  // State and datapath registers; reset aborts any operation in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update; busy/done are derived from the next
  // state so they come straight out of flops.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;

    case (state_q)
      IDLE: begin
        if (load_b) begin
          b_d = S;
          a_d = '0;
          x_d = 1'b0;
        end else if (start) begin
          sgn_d   = mode_signed;
          cnt_d   = '0;
          state_d = CLR;
        end
      end
      CLR: begin
        a_d     = '0;
        x_d     = 1'b0;
        state_d = ADD;
      end
      ADD: begin
        if (b_q[0]) begin
          {x_d, a_d} = w_sum;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        // In signed mode X is the sign and replicates; in unsigned mode it
        // is the carry and is consumed into A.
        x_d = sgn_q ? x_q : 1'b0;
        a_d = {x_q, a_q[N-1:1]};
        b_d = {a_q[0], b_q[N-1:1]};
        if (!w_last) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ADD;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        // A held start must not retrigger; wait for release.
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == CLR) || (state_d == ADD) || (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  assign A    = a_q;
  assign B    = b_q;
  assign X    = x_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_seq_core
//  Description : Directed self-checking bench for mult_seq_core (N=8, N=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_seq_core;

  logic        clk;
  // N = 8 instance
  logic        rst8_n, start8, load8_b, mode8;
  logic [7:0]  s8, a8, b8;
  logic        x8, busy8, done8;
  // N = 16 instance
  logic        rst16_n, start16, load16_b, mode16;
  logic [15:0] s16, a16, b16;
  logic        x16, busy16, done16;

  int tests;
  int fails;
  int lat;

  mult_seq_core #(.N(8)) u_dut8 (
    .clk(clk), .reset_n(rst8_n), .start(start8), .load_b(load8_b),
    .mode_signed(mode8), .S(s8), .A(a8), .B(b8), .X(x8),
    .busy(busy8), .done(done8)
  );

  mult_seq_core #(.N(16)) u_dut16 (
    .clk(clk), .reset_n(rst16_n), .start(start16), .load_b(load16_b),
    .mode_signed(mode16), .S(s16), .A(a16), .B(b16), .X(x16),
    .busy(busy16), .done(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load8(input logic [7:0] v);
    @(negedge clk);
    load8_b = 1'b1;
    s8      = v;
    @(posedge clk); #1;
    load8_b = 1'b0;
  endtask

  // Starts a multiply, measures edges from acceptance to done, checks the
  // single-cycle done pulse, then (optionally after a long hold) releases.
  task automatic mult8(input logic [7:0] v, input logic sgn, input int hold,
                       output int latency);
    int extra;
    @(negedge clk);
    s8 = v; mode8 = sgn; start8 = 1'b1;
    @(posedge clk); #1;
    chk("busy8_after_accept", busy8, 1'b1);
    latency = 0;
    while (!done8 && latency < 100) begin
      @(posedge clk); #1;
      latency++;
    end
    @(posedge clk); #1;
    chk("done8_one_cycle", done8, 1'b0);
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (done8) extra++;
    end
    if (hold > 0) begin
      chk("no_retrigger_done", extra, 0);
      chk("no_retrigger_busy", busy8, 1'b0);
    end
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst8_n = 1'b0; start8 = 0; load8_b = 0; mode8 = 0; s8 = '0;
    rst16_n = 1'b0; start16 = 0; load16_b = 0; mode16 = 0; s16 = '0;
    #12;
    chk("reset_AB", {a8, b8}, 16'h0000);
    chk("reset_X_busy_done", {x8, busy8, done8}, 3'b000);
    @(negedge clk);
    rst8_n = 1'b1; rst16_n = 1'b1;

    // 3 * -2 signed
    do_load8(8'h03);
    chk("load_B", {a8, b8, x8}, {8'h00, 8'h03, 1'b0});
    mult8(8'hFE, 1'b1, 0, lat);
    chk("lat_signed_3x-2", lat, 17);
    chk("prod_signed_3x-2", {a8, b8}, 16'hFFFA);
    chk("x_signed_3x-2", x8, 1'b1);

    // Chain: B=0xFA (-6) times 2
    mult8(8'h02, 1'b1, 0, lat);
    chk("prod_chain", {a8, b8}, 16'hFFF4);
    chk("x_chain", x8, 1'b1);

    // 0xFF * 0xFF both modes
    do_load8(8'hFF);
    mult8(8'hFF, 1'b0, 0, lat);
    chk("prod_unsigned_ff", {a8, b8}, 16'hFE01);
    chk("x_unsigned_ff", x8, 1'b0);
    do_load8(8'hFF);
    mult8(8'hFF, 1'b1, 0, lat);
    chk("prod_signed_ff", {a8, b8}, 16'h0001);
    chk("x_signed_ff", x8, 1'b0);

    // -128 * -128: final-iteration subtract
    do_load8(8'h80);
    mult8(8'h80, 1'b1, 0, lat);
    chk("prod_signed_80", {a8, b8}, 16'h4000);
    chk("x_signed_80", x8, 1'b0);

    // Held start: no second multiply
    do_load8(8'h03);
    mult8(8'hFE, 1'b1, 30, lat);
    chk("prod_after_hold", {a8, b8}, 16'hFFFA);

    // Unsigned with carry: 0xC8 * 0x0A = 0x07D0
    do_load8(8'h0A);
    mult8(8'hC8, 1'b0, 0, lat);
    chk("prod_unsigned_c8", {a8, b8}, 16'h07D0);

    // Reset mid-operation
    do_load8(8'h05);
    @(negedge clk);
    s8 = 8'h07; mode8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2 rst8_n = 1'b0;
    #1;
    chk("midreset_AB", {a8, b8}, 16'h0000);
    chk("midreset_X_busy_done", {x8, busy8, done8}, 3'b000);
    start8 = 1'b0;
    @(negedge clk);
    rst8_n = 1'b1;
    do_load8(8'h05);
    mult8(8'h07, 1'b0, 0, lat);
    chk("post_reset_lat", lat, 17);
    chk("post_reset_prod", {a8, b8}, 16'h0023);

    // N=16: -1 * 0x7FFF signed, with load_b/mode toggling while busy
    @(negedge clk);
    load16_b = 1'b1; s16 = 16'hFFFF;
    @(posedge clk); #1;
    load16_b = 1'b0;
    @(negedge clk);
    s16 = 16'h7FFF; mode16 = 1'b1; start16 = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done16 && lat < 200) begin
      load16_b = lat[0];
      mode16   = ~mode16;
      @(posedge clk); #1;
      lat++;
    end
    load16_b = 1'b0;
    chk("lat16", lat, 33);
    chk("prod16_signed", {a16, b16}, 32'hFFFF8001);
    chk("x16_signed", x16, 1'b1);
    @(negedge clk);
    start16 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("busy16_idle", busy16, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
